alu_muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit, downstream of the ALU operand muxes.
- Consumes operand A (from the A-side mux) and operand B (from alu_input_mux_B out), in parallel with the single-cycle ALU.
- Radix-2 shift-add multiply and restoring divide.
- Fixed latency for every operation; start/busy/done handshake toward the hazard/stall logic.

---
 rtl/klp32_pkg.sv | 31 +++
 rtl/muldiv_sign_fix.sv | 51 +++++
 rtl/alu_muldiv_unit.sv | 126 ++++++++++++
 tb/tb_alu_muldiv_unit.sv | 131 +++++++++++++
 4 files changed

// File: rtl/klp32_pkg.sv
// Shared RV32M encodings and constants for the iterative multiply/divide unit.
package klp32_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    localparam logic [31:0] DIV_BY_ZERO = 32'hFFFF_FFFF;

    // Operand A is treated as signed for MULH, MULHSU, DIV and REM.
    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling: magnitude extraction at accept, and sign
// correction / result selection once the unsigned iteration has finished.
module muldiv_sign_fix
    import klp32_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [2:0]     acc_funct3,
    input  logic [N-1:0]   acc_a,
    input  logic [N-1:0]   acc_b,
    output logic           acc_sign_a,
    output logic           acc_sign_b,
    output logic [N-1:0]   acc_mag_a,
    output logic [N-1:0]   acc_mag_b,

    input  logic [2:0]     fix_funct3,
    input  logic           fix_sign_a,
    input  logic           fix_sign_b,
    input  logic           fix_div_zero,
    input  logic [2*N-1:0] fix_acc,
    input  logic [N-1:0]   fix_quot,
    output logic [N-1:0]   fix_result
);

    logic           neg_res;
    logic [2*N-1:0] prod;
    logic [N-1:0]   quot;
    logic [N-1:0]   rem;

    always_comb begin
        acc_sign_a = a_is_signed(acc_funct3) & acc_a[N-1];
        acc_sign_b = b_is_signed(acc_funct3) & acc_b[N-1];
        acc_mag_a  = acc_sign_a ? -acc_a : acc_a;
        acc_mag_b  = acc_sign_b ? -acc_b : acc_b;
    end

    // Signs were only latched for signed operands, so unsigned ops never negate.
    always_comb begin
        neg_res = fix_sign_a ^ fix_sign_b;
        prod    = neg_res ? -fix_acc : fix_acc;
        quot    = neg_res ? -fix_quot : fix_quot;
        rem     = fix_sign_a ? -fix_acc[2*N-1:N] : fix_acc[2*N-1:N];
        case (fix_funct3)
            F3_MUL:                        fix_result = prod[N-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  fix_result = prod[2*N-1:N];
            F3_DIV, F3_DIVU:               fix_result = fix_div_zero ? N'(DIV_BY_ZERO) : quot;
            default:                       fix_result = rem;
        endcase
    end

endmodule

// File: rtl/alu_muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring
// divide, fixed n+2 cycle latency with start/busy/done handshake.
module alu_muldiv_unit
    import klp32_pkg::*;
#(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   funct3,
    input  logic [n-1:0] operandA,
    input  logic [n-1:0] operandB,
    input  logic         flush,
    output logic [n-1:0] result,
    output logic         busy,
    output logic         done
);

    localparam int CNT_W = $clog2(n);

    md_state_t        state_q, state_d;
    logic [2:0]       op_q;
    logic             sign_a_q, sign_b_q, div0_q;
    logic [n-1:0]     a_q, b_q;
    logic [2*n-1:0]   acc_q;
    logic [CNT_W-1:0] count_q;
    logic [n-1:0]     result_q;

    logic             accept, last_iter;
    logic             sign_a, sign_b;
    logic [n-1:0]     mag_a, mag_b, fix_result;

    logic [n:0]       mul_sum;
    logic [n:0]       div_shift;
    logic [n+1:0]     div_diff;
    logic             q_bit;
    logic [n-1:0]     rem_next;

    assign accept    = (state_q == IDLE) && start && !flush;
    assign last_iter = (count_q == CNT_W'(n-1));
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign result    = result_q;

    muldiv_sign_fix #(.N(n)) u_sign_fix (
        .acc_funct3   (funct3),
        .acc_a        (operandA),
        .acc_b        (operandB),
        .acc_sign_a   (sign_a),
        .acc_sign_b   (sign_b),
        .acc_mag_a    (mag_a),
        .acc_mag_b    (mag_b),
        .fix_funct3   (op_q),
        .fix_sign_a   (sign_a_q),
        .fix_sign_b   (sign_b_q),
        .fix_div_zero (div0_q),
        .fix_acc      (acc_q),
        .fix_quot     (a_q),
        .fix_result   (fix_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (last_iter) state_d = FIX;
            FIX:     state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Multiply: product high half accumulates A, shifting into the low half
    // as the multiplier in b_q is consumed LSB first.
    // Divide: a_q shifts the dividend out MSB first and the quotient in LSB first;
    // the partial remainder lives in acc_q's high half.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*n-1:n]} + {1'b0, (b_q[0] ? a_q : '0)};
        div_shift = {acc_q[2*n-1:n], a_q[n-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, b_q};
        q_bit     = ~div_diff[n+1];
        rem_next  = q_bit ? div_diff[n-1:0] : div_shift[n-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            div0_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q     <= funct3;
                sign_a_q <= sign_a;
                sign_b_q <= sign_b;
                div0_q   <= (operandB == '0);
                a_q      <= mag_a;
                b_q      <= mag_b;
                acc_q    <= '0;
                count_q  <= '0;
            end else if (state_q == CALC) begin
                count_q <= count_q + CNT_W'(1);
                if (op_q[2]) begin
                    acc_q <= {rem_next, acc_q[n-1:0]};
                    a_q   <= {a_q[n-2:0], q_bit};
                end else begin
                    acc_q <= {mul_sum, acc_q[n-1:1]};
                    b_q   <= {1'b0, b_q[n-1:1]};
                end
            end
            if (state_q == FIX && !flush) result_q <= fix_result;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed bench for alu_muldiv_unit: results, exact latency, start-ignore,
// flush abort and asynchronous reset mid-operation.
module tb_alu_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] operandA, operandB;
    logic        flush;
    logic [31:0] result;
    logic        busy, done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_muldiv_unit #(.n(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .funct3   (funct3),
        .operandA (operandA),
        .operandB (operandB),
        .flush    (flush),
        .result   (result),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue at a negedge; cycle 0 ends at the accepting edge. Samples at the
    // negedge of cycles 1..35. A second start can be pulsed in cycle restart_cyc.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag, input int restart_cyc);
        @(negedge clk);
        funct3 = f; operandA = a; operandB = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        operandA = $urandom; operandB = $urandom; funct3 = 3'($urandom_range(0, 7));
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            if (k == restart_cyc + 1) start = 1'b0;
            chk({31'd0, busy}, {31'd0, (k <= 34)}, $sformatf("%s busy c%0d", tag, k));
            chk({31'd0, done}, {31'd0, (k == 34)}, $sformatf("%s done c%0d", tag, k));
            if (k == 34) chk(result, exp, {tag, " result"});
            if (k == restart_cyc) begin
                start = 1'b1; funct3 = 3'b011; operandA = 32'h1234_5678; operandB = 32'h9;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        funct3 = 3'b000; operandA = '0; operandB = '0;
        #12;
        chk(result, 32'h0, "reset result");
        chk({31'd0, busy}, 32'h0, "reset busy");
        chk({31'd0, done}, 32'h0, "reset done");
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3",   0);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ff",   0);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_ff",    0);
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ff",  0);
        run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_ff",     0);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_m7_2",   0);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_m7_2",   0);
        run_op(3'b101, 32'd100,       32'd7,         32'd14,        "divu_100_7", 0);
        run_op(3'b111, 32'd100,       32'd7,         32'd2,         "remu_100_7", 0);
        run_op(3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, "div_by0",    0);
        run_op(3'b111, 32'd5,         32'd0,         32'd5,         "remu_by0",   0);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, "rem_neg_by0", 0);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf",    0);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf",    0);
        run_op(3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_restart", 5);

        // Flush in cycle 10 of a divide: abort with no done, result kept.
        @(negedge clk);
        funct3 = 3'b101; operandA = 32'd100; operandB = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk({31'd0, busy}, 32'h0, "flush busy");
        chk({31'd0, done}, 32'h0, "flush done");
        chk(result, 32'hFFFF_FFEB, "flush result");
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            chk({31'd0, done | busy}, 32'h0, $sformatf("flush quiet c%0d", k));
        end

        // Flush and start together: start is dropped.
        @(negedge clk);
        funct3 = 3'b000; operandA = 32'd2; operandB = 32'd2; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk({31'd0, busy}, 32'h0, "flush_start busy");

        // Asynchronous reset in cycle 20 of a multiply.
        funct3 = 3'b000; operandA = 32'd9; operandB = 32'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 20; k++) @(negedge clk);
        chk({31'd0, busy}, 32'h1, "pre_reset busy");
        rst_n = 1'b0;
        #1;
        chk({31'd0, busy}, 32'h0, "async_rst busy");
        chk({31'd0, done}, 32'h0, "async_rst done");
        chk(result, 32'h0, "async_rst result");
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'b000, 32'd3, 32'd4, 32'd12, "mul_after_rst", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
